// File: rtl/fu_cmd_sequencer_if.sv
// Signal bundle between the command sequencer, its command/response client and
// the shift/rotate functional unit. master = sequencer side, slave = environment side.
interface fu_cmd_sequencer_if #(
   parameter int NBITS = 8,
   parameter int CNT_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_load;
   logic [2:0]       cmd_op;
   logic [NBITS-1:0] cmd_data;
   logic             cmd_msb;
   logic             cmd_lsb;
   logic [CNT_W-1:0] cmd_count;

   logic             fu_m_en;
   logic [2:0]       fu_s;
   logic [NBITS-1:0] fu_f_in;
   logic             fu_msb_in;
   logic             fu_lsb_in;
   logic             fu_data_rdy;
   logic [NBITS-1:0] fu_f_out;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [NBITS-1:0] rsp_data;
   logic             rsp_err;

   modport master (
      input  cmd_valid, cmd_load, cmd_op, cmd_data, cmd_msb, cmd_lsb, cmd_count,
      input  fu_data_rdy, fu_f_out, rsp_ready,
      output cmd_ready, fu_m_en, fu_s, fu_f_in, fu_msb_in, fu_lsb_in,
      output rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      output cmd_valid, cmd_load, cmd_op, cmd_data, cmd_msb, cmd_lsb, cmd_count,
      output fu_data_rdy, fu_f_out, rsp_ready,
      input  cmd_ready, fu_m_en, fu_s, fu_f_in, fu_msb_in, fu_lsb_in,
      input  rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/fu_cmd_sequencer.sv
// Command sequencer for the shift/rotate unit: optional parallel load, then a
// repeated op, returning the last captured F_Out or a timeout error.
module fu_cmd_sequencer #(
   parameter int NBITS       = 8,
   parameter int CNT_W       = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   fu_cmd_sequencer_if.master bus
);

   localparam int         TMO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [2:0] S_IDLE = 3'b000;
   localparam logic [2:0] S_LOAD = 3'b001;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP, RESP} state_e;

   state_e           state_q, state_d;
   logic             load_q, load_d;
   logic [2:0]       op_q, op_d;
   logic [NBITS-1:0] data_q, data_d;
   logic             msb_q, msb_d;
   logic             lsb_q, lsb_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [NBITS-1:0] result_q, result_d;
   logic             err_q, err_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic [TMO_W-1:0] tmo_inc;
   logic             more;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         load_q      <= 1'b0;
         op_q        <= 3'b000;
         data_q      <= '0;
         msb_q       <= 1'b0;
         lsb_q       <= 1'b0;
         remaining_q <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         load_q      <= load_d;
         op_q        <= op_d;
         data_q      <= data_d;
         msb_q       <= msb_d;
         lsb_q       <= lsb_d;
         remaining_q <= remaining_d;
         result_q    <= result_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      load_d      = load_q;
      op_d        = op_q;
      data_d      = data_q;
      msb_d       = msb_q;
      lsb_d       = lsb_q;
      remaining_d = remaining_q;
      result_d    = result_q;
      err_d       = err_q;
      tmo_d       = tmo_q;
      tmo_inc     = tmo_q + TMO_W'(1);
      more        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               load_d      = bus.cmd_load;
               op_d        = bus.cmd_op;
               data_d      = bus.cmd_data;
               msb_d       = bus.cmd_msb;
               lsb_d       = bus.cmd_lsb;
               remaining_d = bus.cmd_count;
               result_d    = '0;
               err_d       = 1'b0;
               tmo_d       = '0;
               state_d     = (bus.cmd_load || bus.cmd_count != '0) ? ISSUE : RESP;
            end
         end
         ISSUE: begin
            // x/z on the strobe compares unknown and falls through to the timeout path
            if (bus.fu_data_rdy == 1'b1) begin
               result_d = bus.fu_f_out;
               tmo_d    = '0;
               if (!load_q && remaining_q != '0) remaining_d = remaining_q - CNT_W'(1);
               more     = load_q ? (remaining_q != '0) : (remaining_q > CNT_W'(1));
               load_d   = 1'b0;
               state_d  = more ? GAP : RESP;
            end else if (tmo_inc == TMO_W'(TIMEOUT_CYC)) begin
               err_d   = 1'b1;
               tmo_d   = '0;
               state_d = RESP;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         GAP:     state_d = ISSUE;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = 1'b0;
      bus.fu_m_en   = 1'b0;
      bus.fu_s      = S_IDLE;
      bus.fu_f_in   = '0;
      bus.fu_msb_in = 1'b0;
      bus.fu_lsb_in = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = result_q;
      bus.rsp_err   = err_q;

      // operand lines stay on the bus from acceptance until the response is taken
      if (state_q != IDLE) begin
         bus.fu_f_in   = data_q;
         bus.fu_msb_in = msb_q;
         bus.fu_lsb_in = lsb_q;
      end

      case (state_q)
         IDLE:  bus.cmd_ready = reset_n;
         ISSUE: begin
            bus.fu_m_en = 1'b1;
            bus.fu_s    = load_q ? S_LOAD : op_q;
         end
         RESP:  bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fu_cmd_sequencer.sv
// Bench for fu_cmd_sequencer: behavioural shift/rotate unit, window monitor and
// a response scoreboard fed as commands are driven.
module tb_fu_cmd_sequencer;

   logic clk;
   logic reset_n;

   fu_cmd_sequencer_if #(.NBITS(8), .CNT_W(4)) bus ();

   fu_cmd_sequencer #(.NBITS(8), .CNT_W(4), .TIMEOUT_CYC(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } rsp_t;

   rsp_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] fu_apply(input logic [7:0] r, input logic [2:0] s,
                                           input logic [7:0] fin, input logic msb, input logic lsb);
      case (s)
         3'b000:  return r;
         3'b001:  return fin;
         3'b010:  return {msb, r[7:1]};
         3'b011:  return {r[6:0], lsb};
         3'b100:  return {r[0], r[7:1]};
         3'b101:  return {r[6:0], r[7]};
         3'b110:  return {r[7], r[7:1]};
         default: return {r[6:0], 1'b0};
      endcase
   endfunction

   // shift/rotate unit: strobes fu_lat cycles into each enable window
   int         fu_lat   = 0;
   int         fu_limit = 32'h7fffffff;
   int         fu_nstb  = 0;
   int         strobe_cyc = 0;
   logic [7:0] fu_reg;
   int         fu_wait;
   bit         fu_done;

   initial begin
      bus.fu_data_rdy = 1'b0;
      bus.fu_f_out    = '0;
      fu_reg  = '0;
      fu_wait = 0;
      fu_done = 1'b0;
      forever begin
         @(negedge clk);
         bus.fu_data_rdy = 1'b0;
         if (bus.fu_m_en === 1'b1) begin
            if (!fu_done && fu_nstb < fu_limit) begin
               if (fu_wait >= fu_lat) begin
                  fu_reg = fu_apply(fu_reg, bus.fu_s, bus.fu_f_in, bus.fu_msb_in, bus.fu_lsb_in);
                  bus.fu_f_out    = fu_reg;
                  bus.fu_data_rdy = 1'b1;
                  fu_done    = 1'b1;
                  fu_nstb++;
                  strobe_cyc = cyc;
               end else begin
                  fu_wait++;
               end
            end
         end else begin
            fu_wait = 0;
            fu_done = 1'b0;
         end
      end
   end

   // enable-window monitor
   bit         exp_load;
   logic [2:0] exp_op;
   logic [7:0] exp_fin;
   bit         exp_msb, exp_lsb;
   int         win_base = 0, gap_base = 0, s_base = 0;
   int         tot_windows = 0, gap_errs = 0, s_errs = 0;
   int         hi_run = 0, low_run = 0;
   bit         m_prev = 1'b0;
   logic [2:0] mon_s;

   initial begin
      forever begin
         @(negedge clk);
         if (bus.fu_m_en === 1'b1) begin
            if (!m_prev) begin
               if (tot_windows != win_base && low_run != 1) gap_errs++;
               tot_windows++;
               hi_run = 0;
            end
            hi_run++;
            low_run = 0;
            mon_s = (tot_windows - win_base == 1 && exp_load) ? 3'b001 : exp_op;
            if (bus.fu_s !== mon_s || bus.fu_f_in !== exp_fin ||
                bus.fu_msb_in !== exp_msb || bus.fu_lsb_in !== exp_lsb) s_errs++;
         end else begin
            low_run++;
            if (bus.fu_s !== 3'b000) s_errs++;
         end
         m_prev = (bus.fu_m_en === 1'b1);
      end
   end

   task automatic check_zero_outs(input string tag);
      check_val({tag, "_cmd_ready"}, bus.cmd_ready, 0);
      check_val({tag, "_m_en"},      bus.fu_m_en, 0);
      check_val({tag, "_fu_s"},      bus.fu_s, 0);
      check_val({tag, "_f_in"},      bus.fu_f_in, 0);
      check_val({tag, "_msb_in"},    bus.fu_msb_in, 0);
      check_val({tag, "_lsb_in"},    bus.fu_lsb_in, 0);
      check_val({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      check_val({tag, "_rsp_data"},  bus.rsp_data, 0);
      check_val({tag, "_rsp_err"},   bus.rsp_err, 0);
   endtask

   task automatic send_cmd(input bit ld, input logic [2:0] op, input logic [7:0] d,
                           input bit msb, input bit lsb, input logic [3:0] cnt,
                           input logic [7:0] exp_d, input bit exp_e, output int waited);
      waited = 0;
      @(negedge clk);
      bus.cmd_load  = ld;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      bus.cmd_msb   = msb;
      bus.cmd_lsb   = lsb;
      bus.cmd_count = cnt;
      bus.cmd_valid = 1'b1;
      exp_load = ld;
      exp_op   = op;
      exp_fin  = d;
      exp_msb  = msb;
      exp_lsb  = lsb;
      while (bus.cmd_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check_val("cmd_ready", bus.cmd_ready, 1);
      exp_q.push_back({exp_e, exp_d});
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      win_base = tot_windows;
      gap_base = gap_errs;
      s_base   = s_errs;
      @(negedge clk);
      check_val("m_en_lat", bus.fu_m_en, ld || (cnt != 0));
   endtask

   task automatic wait_rsp(input int exp_win, input int exp_hi, input bit chk_lat, input bit ack);
      int   n;
      rsp_t e;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.rsp_valid !== 1'b1 && n < 600);
      check_val("rsp_valid", bus.rsp_valid, 1);
      check_val("sb_depth", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check_val("rsp_data", bus.rsp_data, e.data);
         check_val("rsp_err",  bus.rsp_err,  e.err);
      end
      check_val("windows",  tot_windows - win_base, exp_win);
      check_val("gap_errs", gap_errs - gap_base, 0);
      check_val("sel_errs", s_errs - s_base, 0);
      if (exp_hi != 0) check_val("win_len", hi_run, exp_hi);
      if (chk_lat) check_val("rsp_lat", cyc - strobe_cyc, 1);
      if (ack) begin
         bus.rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.rsp_ready = 1'b0;
         check_val("ack_cmd_ready", bus.cmd_ready, 1);
         check_val("ack_rsp_valid", bus.rsp_valid, 0);
      end
   endtask

   int         w;
   logic [7:0] rnd_d, rnd_exp;
   logic [2:0] rnd_op;
   logic [3:0] rnd_cnt;
   bit         rnd_m, rnd_l;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_load  = 1'b0;
      bus.cmd_op    = 3'b000;
      bus.cmd_data  = '0;
      bus.cmd_msb   = 1'b0;
      bus.cmd_lsb   = 1'b0;
      bus.cmd_count = '0;
      bus.rsp_ready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero_outs("por");
      reset_n = 1'b1;
      #1 check_val("por_cmd_ready", bus.cmd_ready, 1);

      send_cmd(1'b1, 3'b000, 8'hAA, 1'b0, 1'b0, 4'd0, 8'hAA, 1'b0, w);
      wait_rsp(1, 1, 1'b1, 1'b1);

      fu_lat = 2;
      send_cmd(1'b1, 3'b110, 8'h8C, 1'b0, 1'b0, 4'd2, 8'hE3, 1'b0, w);
      wait_rsp(3, 3, 1'b1, 1'b1);

      fu_lat = 0;
      send_cmd(1'b1, 3'b100, 8'h7F, 1'b0, 1'b0, 4'd8, 8'h7F, 1'b0, w);
      wait_rsp(9, 1, 1'b1, 1'b1);
      send_cmd(1'b0, 3'b011, 8'h00, 1'b0, 1'b1, 4'd1, 8'hFF, 1'b0, w);
      wait_rsp(1, 1, 1'b1, 1'b1);

      send_cmd(1'b0, 3'b101, 8'h33, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, w);
      wait_rsp(0, 0, 1'b0, 1'b1);

      fu_lat = 1;
      send_cmd(1'b1, 3'b101, 8'h01, 1'b0, 1'b0, 4'd15, 8'h80, 1'b0, w);
      wait_rsp(16, 2, 1'b1, 1'b1);

      fu_lat   = 0;
      fu_limit = fu_nstb;
      send_cmd(1'b1, 3'b110, 8'h55, 1'b0, 1'b0, 4'd3, 8'h00, 1'b1, w);
      wait_rsp(1, 16, 1'b0, 1'b1);

      fu_limit = fu_nstb + 2;
      send_cmd(1'b1, 3'b011, 8'h3C, 1'b0, 1'b0, 4'd3, 8'h78, 1'b1, w);
      wait_rsp(3, 16, 1'b0, 1'b1);
      fu_limit = 32'h7fffffff;

      send_cmd(1'b1, 3'b010, 8'h3C, 1'b1, 1'b0, 4'd1, 8'h9E, 1'b0, w);
      wait_rsp(2, 1, 1'b1, 1'b0);
      bus.cmd_load  = 1'b1;
      bus.cmd_op    = 3'b000;
      bus.cmd_data  = 8'h12;
      bus.cmd_count = 4'd0;
      bus.cmd_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check_val("bp_rsp_valid", bus.rsp_valid, 1);
         check_val("bp_rsp_data",  bus.rsp_data, 8'h9E);
         check_val("bp_rsp_err",   bus.rsp_err, 0);
         check_val("bp_cmd_ready", bus.cmd_ready, 0);
         check_val("bp_m_en",      bus.fu_m_en, 0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      send_cmd(1'b1, 3'b000, 8'h12, 1'b0, 1'b0, 4'd0, 8'h12, 1'b0, w);
      check_val("bp_accept_wait", w, 0);
      wait_rsp(1, 1, 1'b1, 1'b1);

      fu_lat = 6;
      send_cmd(1'b1, 3'b101, 8'h99, 1'b0, 1'b1, 4'd2, 8'h00, 1'b0, w);
      void'(exp_q.pop_back());
      reset_n = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_zero_outs("rst");
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1 check_val("rst_cmd_ready", bus.cmd_ready, 1);
      @(negedge clk);
      check_val("rst_rsp_valid", bus.rsp_valid, 0);
      check_val("rst_m_en", bus.fu_m_en, 0);

      fu_lat = 0;
      send_cmd(1'b1, 3'b011, 8'h5A, 1'b0, 1'b0, 4'd1, 8'hB4, 1'b0, w);
      wait_rsp(2, 1, 1'b1, 1'b1);

      for (int i = 0; i < 4; i++) begin
         rnd_d   = 8'($urandom);
         rnd_op  = 3'($urandom_range(7, 2));
         rnd_cnt = 4'($urandom_range(4, 0));
         rnd_m   = 1'($urandom);
         rnd_l   = 1'($urandom);
         fu_lat  = int'($urandom_range(2, 0));
         rnd_exp = rnd_d;
         for (int k = 0; k < int'(rnd_cnt); k++)
            rnd_exp = fu_apply(rnd_exp, rnd_op, rnd_d, rnd_m, rnd_l);
         send_cmd(1'b1, rnd_op, rnd_d, rnd_m, rnd_l, rnd_cnt, rnd_exp, 1'b0, w);
         wait_rsp(1 + int'(rnd_cnt), fu_lat + 1, 1'b1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
